fb_write_arbiter: RTL
=====================

# fb_write_arbiter

Shares the single frame-buffer SRAM write port between up to NUM_CLIENTS fill/pattern engines, such as the gradient generator, clear-screen and overlay writers. Each engine keeps its existing enable/done/pause handshake. The arbiter grants one engine at a time in round-robin order, muxes that engine's addr/data/wren onto the memory port through one register stage, and holds every other engine paused. It sits between the engines and the SRAM controller.

## Interface
- NUM_CLIENTS, 4: number of writer engines (2..8).
- ADDR_W, 18: frame-buffer word address width.
- DATA_W, 32: write data width.
- WATCHDOG_CYCLES, 131072: grant timeout; used only with FB_ARB_WATCHDOG_EN.

- clk: in, 1. Single clock for the whole block.
- reset_n: in, 1. Reset is asynchronous and active-low.
- req: in, NUM_CLIENTS. Bit i means client i wants the port.
- client_enable: out, NUM_CLIENTS. Enable to each client.
- client_pause: out, NUM_CLIENTS. Stall to each client.
- client_done: in, NUM_CLIENTS. Client's held done flag.
- client_addr: in, NUM_CLIENTS*ADDR_W. Packed; client i occupies [i*ADDR_W +: ADDR_W].
- client_data_write: in, NUM_CLIENTS*DATA_W. Packed the same way.
- client_wren: in, NUM_CLIENTS. Client write strobes.
- mem_busy: in, 1. SRAM controller cannot accept a write this cycle.
- mem_addr: out, ADDR_W. Registered.
- mem_data_write: out, DATA_W. Registered.
- mem_wren: out, 1. Registered.
- grant_id: out, clog2(NUM_CLIENTS). Current or last granted client.
- busy: out, 1. High in every state except IDLE.
- job_done: out, NUM_CLIENTS. One-cycle pulse when client i's job completes.
- fault: out, NUM_CLIENTS. Sticky watchdog flag; tied to 0 without the macro.

## Operation
- Reset values:
  - client_enable = 0 and client_pause = all 1s.
  - mem_addr, mem_data_write and mem_wren = 0.
  - grant_id = 0, busy = 0, job_done = 0, fault = 0.
  - Round-robin pointer = NUM_CLIENTS-1, so client 0 wins first.
- States are IDLE, GRANT and RELEASE.
- IDLE:
  - If req is nonzero, pick the first set bit searching upward from pointer+1, with wrap-around.
  - Register the pick in grant_id, set client_enable[g] = 1, and go to GRANT.
- GRANT:
  - client_pause[g] = mem_busy, combinational. Every other client_pause bit = 1.
  - Memory outputs capture client g's addr and data only when mem_busy = 0.
  - mem_wren <= client_wren[g] & ~mem_busy. A paused client therefore never produces a duplicate write.
  - When client_done[g] = 1: drop client_enable[g], pulse job_done[g], set pointer = g, go to RELEASE.
- RELEASE:
  - mem_wren = 0 and all client_pause bits = 1.
  - Go to IDLE when client_done[g] = 0, i.e. the client has left its cleanup state.
- Deasserting req[g] during GRANT or RELEASE is ignored. The grant ends only through done or the watchdog.
- Requests from non-granted clients are held off with no limit. The round-robin order guarantees each is served within NUM_CLIENTS jobs.
- If several requests are asserted in the same cycle, exactly one is granted. The rest wait.
- If reset_n is asserted in mid-job, all outputs return to their reset values immediately. An in-flight write is dropped.

## Timing
- req[i] high at edge t while IDLE → client_enable[i] high after edge t.
- Datapath latency: client outputs at edge t appear on mem_* after edge t+1.
- When mem_busy is high at edge t, mem_wren is 0 after that edge and client_pause[g] is high in the same cycle.
- client_done[g] seen at edge t:
  - client_enable[g] = 0 and job_done[g] = 1 after edge t.
  - job_done clears one cycle later.
- Minimum gap between consecutive grants is 2 cycles: RELEASE takes 1 cycle, IDLE takes 1 cycle.

## Configuration
- FB_ARB_WATCHDOG_EN defined:
  - A counter of ceil(log2(WATCHDOG_CYCLES+1)) bits clears on each grant and counts cycles spent in GRANT.
  - When it reaches WATCHDOG_CYCLES without done, the arbiter sets fault[g] (sticky until reset), drops client_enable[g], and goes to RELEASE.
  - No job_done pulse is issued on a timeout.
- FB_ARB_WATCHDOG_EN undefined:
  - No counter is built and fault is constant 0.
  - GRANT is held until done arrives.

## Structure
- Shared package fb_arb_pkg holds the state enum (IDLE, GRANT, RELEASE) and the defaults FB_ADDR_W = 18, FB_DATA_W = 32 and FB_PIXEL_COUNT = 76800.
- One sub-module, rr_pick: combinational round-robin first-set search taking (req, pointer) and giving (valid, index). It is instantiated once.

## Test plan
- **Single client:** req = 4'b0001; the client writes 3 words (addr 0..2, data 0x100, 0x200, 0x300) then raises done → mem_* shows the 3 writes one cycle delayed, job_done[0] pulses once, and busy returns to 0 two cycles after done drops.
- **Contention:** req = 4'b1011 held, each client finishing after 2 writes → grant order is 0, 1, 3, 0, and client_pause is 1 for every non-granted client throughout.
- **Memory stall:** mem_busy held high for 3 cycles mid-job → client_pause[g] is high for exactly those cycles, mem_wren is 0, and there is no repeated write to the same address.
- **Reset mid-job:** reset_n pulled low in GRANT with mem_wren = 1 → all outputs go to their reset values asynchronously; after release, client 0 is granted first.
- **Watchdog:** with FB_ARB_WATCHDOG_EN and WATCHDOG_CYCLES = 16, client 2 never raises done → fault[2] = 1 at cycle 16 of GRANT, its enable drops, client 3 is granted next, and job_done[2] stays 0.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared types and frame-buffer defaults for the write-port arbiter.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int FB_ADDR_W      = 18;
  localparam int FB_DATA_W      = 32;
  localparam int FB_PIXEL_COUNT = 76800;

endpackage

// File: rtl/fb_write_arbiter_rr_pick.sv
// Round-robin first-set search starting just above ptr, wrapping; combinational.
// No state, no backpressure.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             base;
  int             pos;

  always_comb begin
    base  = (int'(ptr) + 1 >= N) ? 0 : int'(ptr) + 1;
    // Rotating a doubled copy puts the search start at bit 0.
    dbl   = {req, req} >> base;
    rot   = dbl[N-1:0];
    valid = 1'b0;
    pos   = 0;
    for (int i = 0; i < N; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        pos   = base + i;
      end
    end
    if (pos >= N) pos = pos - N;
    index = IW'(pos);
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin owner of the frame-buffer write port; one register stage to mem_*.
// mem_busy pauses the owner combinationally; others stay paused. Watchdog: FB_ARB_WATCHDOG_EN.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int NUM_CLIENTS     = 4,
  parameter int ADDR_W          = FB_ADDR_W,
  parameter int DATA_W          = FB_DATA_W,
  parameter int WATCHDOG_CYCLES = 131072
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CLIENTS-1:0]         req,
  output logic [NUM_CLIENTS-1:0]         client_enable,
  output logic [NUM_CLIENTS-1:0]         client_pause,
  input  logic [NUM_CLIENTS-1:0]         client_done,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]  client_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0]  client_data_write,
  input  logic [NUM_CLIENTS-1:0]         client_wren,
  input  logic                           mem_busy,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_data_write,
  output logic                           mem_wren,
  output logic [$clog2(NUM_CLIENTS)-1:0] grant_id,
  output logic                           busy,
  output logic [NUM_CLIENTS-1:0]         job_done,
  output logic [NUM_CLIENTS-1:0]         fault
);

  localparam int IW = $clog2(NUM_CLIENTS);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic          timeout;

  rr_pick #(.N(NUM_CLIENTS)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .index (pick_idx)
  );

  always_comb begin
    client_pause = '1;
    if (state == GRANT) client_pause[grant_id] = mem_busy;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ptr            <= IW'(NUM_CLIENTS - 1);
      grant_id       <= '0;
      client_enable  <= '0;
      job_done       <= '0;
      mem_addr       <= '0;
      mem_data_write <= '0;
      mem_wren       <= 1'b0;
    end else begin
      job_done <= '0;
      mem_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_id                <= pick_idx;
            client_enable[pick_idx] <= 1'b1;
            state                   <= GRANT;
          end
        end
        GRANT: begin
          // A stalled cycle writes nothing; the paused client re-presents the same word.
          mem_wren <= client_wren[grant_id] & ~mem_busy;
          if (!mem_busy) begin
            mem_addr       <= client_addr[int'(grant_id)*ADDR_W +: ADDR_W];
            mem_data_write <= client_data_write[int'(grant_id)*DATA_W +: DATA_W];
          end
          if (client_done[grant_id]) begin
            client_enable[grant_id] <= 1'b0;
            job_done[grant_id]      <= 1'b1;
            ptr                     <= grant_id;
            state                   <= RELEASE;
          end else if (timeout) begin
            client_enable[grant_id] <= 1'b0;
            ptr                     <= grant_id;
            state                   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!client_done[grant_id]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FB_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);

  logic [WDW-1:0] wd_cnt;

  // Counter value equals GRANT cycles already completed; the last one fires.
  assign timeout = (state == GRANT) && !client_done[grant_id] &&
                   (wd_cnt == WDW'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
      fault  <= '0;
    end else begin
      if (state != GRANT) wd_cnt <= '0;
      else                wd_cnt <= wd_cnt + 1'b1;
      if (timeout) fault[grant_id] <= 1'b1;
    end
  end
`else
  logic wd_cfg_unused;

  assign wd_cfg_unused = (WATCHDOG_CYCLES == 0);
  assign timeout       = 1'b0;
  assign fault         = '0;
`endif

endmodule
